// File: rtl/mips_pkg.sv
// Shared MIPS fetch-side constants: main-decoder opcodes, default halt word,
// masked opcode presented while halted, and the fetch FSM state type.
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE           = 6'h00;
    localparam logic [5:0]  OP_LW              = 6'h23;
    localparam logic [5:0]  OP_SW              = 6'h2B;
    localparam logic [5:0]  OP_BEQ             = 6'h04;
    localparam logic [5:0]  OP_ADDI            = 6'h08;
    localparam logic [5:0]  OP_J               = 6'h02;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_000C;
    localparam logic [5:0]  OPCODE_MASKED      = 6'b111111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: jump target, taken-branch target or sequential PC.
// Jump has priority over a taken branch.
module pc_next_mux
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_low,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] pc_next
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Target arithmetic and priority select; all adds wrap modulo 2^32.
    always_comb begin
        branch_target = pc_plus4 + (sign_ext16(instr_low[15:0]) << 2);
        jump_target   = {pc_plus4[31:28], instr_low, 2'b00};
        if (jump) begin
            pc_next = jump_target;
        end else if (branch && zero) begin
            pc_next = branch_target;
        end else begin
            pc_next = pc_plus4;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit with RUN/HALT sequencing.
// Optional branch/jump statistics counters are compiled in with the macro
// PC_FETCH_BRANCH_STATS_EN (default build: no counters, no counter ports).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | fetching; PC advances on every non-stalled cycle
// ST_HALT | halt word was seen; PC frozen, Opcode masked, exit by rst only
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    input  logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [5:0]  Opcode,
    output logic        Halted
`ifdef PC_FETCH_BRANCH_STATS_EN
    ,
    output logic [15:0] BranchTakenCnt,
    output logic [15:0] JumpCnt
`endif
);

    // Low bits are dropped so the PC stays word-aligned even for a sloppy RESET_PC.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_next;
    logic         run_adv;
    logic         halt_hit;

    pc_next_mux u_pc_next_mux (
        .pc_plus4  (PCPlus4),
        .instr_low (Instr[25:0]),
        .branch    (Branch),
        .zero      (Zero),
        .jump      (Jump),
        .pc_next   (pc_next)
    );

    // Qualifiers: a RUN cycle without stall is the only cycle that does work.
    always_comb begin
        run_adv  = (state_q == ST_RUN) && !Stall;
        halt_hit = (Instr == HALT_INSTR);
    end

    // State and PC registers; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC_ALIGNED;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state: halt word takes priority over any branch/jump; HALT is sticky.
    always_comb begin
        state_d = state_q;
        if (run_adv && halt_hit) begin
            state_d = ST_HALT;
        end
    end

    // Next PC: advance only on a working cycle that is not the halting one.
    always_comb begin
        pc_d = pc_q;
        if (run_adv && !halt_hit) begin
            pc_d = pc_next;
        end
    end

    // Outputs: registered PC, sequential address, halt status and masked opcode.
    always_comb begin
        PC      = pc_q;
        PCPlus4 = pc_q + 32'd4;
        Halted  = (state_q == ST_HALT);
        Opcode  = (state_q == ST_HALT) ? OPCODE_MASKED : Instr[31:26];
    end

`ifdef PC_FETCH_BRANCH_STATS_EN
    logic [15:0] bcnt_q, bcnt_d;
    logic [15:0] jcnt_q, jcnt_d;

    // Saturating event counters for taken branches and jumps.
    always_comb begin
        bcnt_d = bcnt_q;
        jcnt_d = jcnt_q;
        if (run_adv && Jump && (jcnt_q != 16'hFFFF)) begin
            jcnt_d = jcnt_q + 16'd1;
        end
        if (run_adv && Branch && Zero && !Jump && (bcnt_q != 16'hFFFF)) begin
            bcnt_d = bcnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q <= 16'd0;
            jcnt_q <= 16'd0;
        end else begin
            bcnt_q <= bcnt_d;
            jcnt_q <= jcnt_d;
        end
    end

    // Counter outputs.
    always_comb begin
        BranchTakenCnt = bcnt_q;
        JumpCnt        = jcnt_q;
    end
`endif

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset (word-aligned).
REQ-002 SHALL have parameter HALT_INSTR, default 32'h0000_000C, meaning the instruction word that stops fetch.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port Stall, input, 1 bit: hold PC and FSM this cycle.
REQ-006 SHALL have ports Branch, Jump, input, 1 bit each: control outputs of the main decoder.
REQ-007 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-008 SHALL have port Instr, input, 32 bits: asynchronous instruction-memory read data at address PC.
REQ-009 SHALL have port PC, output, 32 bits: current instruction address, registered.
REQ-010 SHALL have port PCPlus4, output, 32 bits: PC + 4, combinational.
REQ-011 SHALL have port Opcode, output, 6 bits: Instr[31:26] to the main decoder, masked when halted.
REQ-012 SHALL have port Halted, output, 1 bit: high in HALT state.

Function
REQ-013 SHALL compute PCPlus4 = PC + 32'd4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-014 SHALL compute branch target = PCPlus4 + (sign-extend(Instr[15:0]) << 2), modulo 2^32.
REQ-015 SHALL compute jump target = {PCPlus4[31:28], Instr[25:0], 2'b00}.
REQ-016 SHALL select next PC by priority: Jump, then (Branch & Zero), then PCPlus4.
REQ-017 SHALL leave PC unchanged in any cycle with Stall = 1, regardless of Branch/Jump/Zero.
REQ-018 SHALL keep PC[1:0] = 2'b00 at all times.
REQ-019 SHALL implement FSM states RUN and HALT.
REQ-020 SHALL go RUN -> HALT when Instr == HALT_INSTR and Stall = 0; PC SHALL NOT advance on that edge.
REQ-021 SHALL treat HALT as sticky; only rst leaves it; Stall in HALT has no effect.
REQ-022 SHALL drive Opcode = 6'b111111 whenever FSM is HALT, else Instr[31:26] (combinational).
REQ-023 SHALL hold PC constant in HALT.
REQ-024 SHALL give the HALT transition priority over Jump/Branch when Instr == HALT_INSTR.

Reset
REQ-025 SHALL, on rising clk with rst = 1, load PC = RESET_PC, FSM = RUN, Halted = 0, all counters = 0.
REQ-026 SHALL give rst priority over Stall, halt and any branch/jump in the same cycle, including mid-halt.

Configuration
REQ-027 SHALL compile in, when macro PC_FETCH_BRANCH_STATS_EN is defined, outputs BranchTakenCnt[15:0] and JumpCnt[15:0].
REQ-028 SHALL, with the macro, increment BranchTakenCnt on each non-stalled RUN cycle with Branch & Zero & ~Jump, and JumpCnt on each non-stalled RUN cycle with Jump; both saturate at 16'hFFFF.
REQ-029 SHALL, without the macro, omit these ports and counter registers entirely; all other behaviour identical.

Structure
REQ-030 SHALL place opcode constants (R-type, lw, sw, beq, addi, j), HALT_INSTR default and masked opcode 6'b111111 in shared package mips_pkg.
REQ-031 SHALL implement the target computation and priority select (REQ-014..016) in combinational sub-module pc_next_mux.

Verification
REQ-032 SHALL cover: reset, then 3 cycles, Instr = addi, no control -> PC 0x0, 0x4, 0x8, 0xC.
REQ-033 SHALL cover: PC = 0x10, beq imm = 16'hFFFC, Branch = 1, Zero = 1 -> next PC 0x4; same with Zero = 0 -> next PC 0x14.
REQ-034 SHALL cover: PC = 0x20, Jump = 1, Branch = 1, Zero = 1, Instr[25:0] = 26'h40 -> next PC 0x100 (jump wins).
REQ-035 SHALL cover: PC = 0x30, Stall = 1 for 2 cycles with Jump = 1 -> PC stays 0x30, counters unchanged.
REQ-036 SHALL cover: Instr = 32'h0000000C at PC = 0x40 -> Halted = 1, PC stays 0x40, Opcode = 6'b111111; rst -> PC = 0x0, Halted = 0.
REQ-037 SHALL cover: PC = 0xFFFF_FFFC, no control -> next PC 0x0; with macro, 65540 taken branches -> BranchTakenCnt = 16'hFFFF.
